// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus responder: cycle classification, FSM
// state encoding and the wait-counter width.
package z80_bus_pkg;

  localparam int WAITW = 4;

  typedef enum logic [2:0] {
    CYC_NONE = 3'd0,
    CYC_MRD  = 3'd1,
    CYC_MWR  = 3'd2,
    CYC_IORD = 3'd3,
    CYC_IOWR = 3'd4,
    CYC_INTA = 3'd5
  } cyc_t;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WAITCNT = 3'd1;
  localparam state_t ST_FETCH   = 3'd2;
  localparam state_t ST_DRIVE   = 3'd3;
  localparam state_t ST_WRDONE  = 3'd4;

  // Memory cycles take MEM_WAIT; everything else (IO, INTA) takes IO_WAIT
  function automatic logic is_mem(cyc_t c);
    return (c == CYC_MRD) || (c == CYC_MWR);
  endfunction

endpackage

// File: rtl/z80_bus_cycle_decode.sv
// Combinational classification of the Z80 control strobes into a bus
// cycle type. Refresh and the illegal nRD&nWR combination map to CYC_NONE.
module z80_bus_cycle_decode
  import z80_bus_pkg::*;
(
  input  logic nM1,
  input  logic nMREQ,
  input  logic nIORQ,
  input  logic nRD,
  input  logic nWR,
  input  logic nRFSH,
  output cyc_t cyc
);

  // Priority decode; memory beats IO if both requests are somehow low
  always_comb begin
    cyc = CYC_NONE;
    if (!nRD && !nWR) begin
      cyc = CYC_NONE;
    end else if (!nMREQ && nRFSH && !nRD) begin
      cyc = CYC_MRD;
    end else if (!nMREQ && nRFSH && !nWR) begin
      cyc = CYC_MWR;
    end else if (!nIORQ && !nM1) begin
      cyc = CYC_INTA;
    end else if (!nIORQ && !nRD) begin
      cyc = CYC_IORD;
    end else if (!nIORQ && !nWR) begin
      cyc = CYC_IOWR;
    end
  end

endmodule

// File: rtl/z80_bus_responder.sv
// Synchronous memory/IO slave for the Z80 core. Decodes bus cycles in
// IDLE, inserts wait states, fronts a 1-cycle-latency RAM and an 8-bit
// port space, and returns read data on a split data bus.
// Optional macro Z80_BUS_ROM_PROTECT_EN: drop memory writes below ROM_TOP
// and flag them on rom_wr_err.
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter int          MEM_WAIT = 0,
  parameter int          IO_WAIT  = 1,
  parameter logic [15:0] ROM_TOP  = 16'h4000
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [15:0] A,
  input  logic [7:0]  D_in,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic        nM1,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nRFSH,
  output logic        nWAIT,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_wr,
  output logic        io_rd,
  input  logic [7:0]  io_rdata,
  input  logic [7:0]  int_vector,
  output logic        intack,
  output logic        rom_wr_err
);

  if (MEM_WAIT < 0 || MEM_WAIT > 15) begin : g_bad_mem_wait
    $error("MEM_WAIT must be in 0..15");
  end
  if (IO_WAIT < 0 || IO_WAIT > 15) begin : g_bad_io_wait
    $error("IO_WAIT must be in 0..15");
  end

  localparam logic [WAITW-1:0] MEM_WAIT_C = WAITW'(MEM_WAIT);
  localparam logic [WAITW-1:0] IO_WAIT_C  = WAITW'(IO_WAIT);

`ifdef Z80_BUS_ROM_PROTECT_EN
  localparam bit ROM_PROT = 1'b1;
`else
  localparam bit ROM_PROT = 1'b0;
`endif

  state_t           state_q, state_d;
  cyc_t             cyc_q, cyc_d;
  logic [WAITW-1:0] cnt_q, cnt_d;
  logic [15:0]      mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic [7:0]       io_addr_q, io_addr_d;
  logic [7:0]       io_wdata_q, io_wdata_d;
  logic [7:0]       d_out_q, d_out_d;
  logic             mem_we_q, mem_we_d;
  logic             mem_re_q, mem_re_d;
  logic             io_wr_q, io_wr_d;
  logic             io_rd_q, io_rd_d;
  logic             intack_q, intack_d;
  logic             rom_wr_err_q, rom_wr_err_d;

  cyc_t             cyc_dec;
  cyc_t             act_cyc;
  logic [15:0]      act_addr;
  logic [WAITW-1:0] wait_ld;
  logic             rom_hit;
  logic             strobe_on;
  logic             do_act;

  z80_bus_cycle_decode u_dec (
    .nM1   (nM1),
    .nMREQ (nMREQ),
    .nIORQ (nIORQ),
    .nRD   (nRD),
    .nWR   (nWR),
    .nRFSH (nRFSH),
    .cyc   (cyc_dec)
  );

  // The action fires either straight out of IDLE (zero waits, fresh decode
  // and live address) or at the end of WAITCNT (latched cycle/address).
  assign act_cyc  = (state_q == ST_IDLE) ? cyc_dec : cyc_q;
  assign act_addr = (state_q == ST_IDLE) ? A : mem_addr_q;
  assign rom_hit  = ROM_PROT && (act_addr < ROM_TOP);
  assign wait_ld  = is_mem(cyc_dec) ? MEM_WAIT_C : IO_WAIT_C;

  // Is the strobe that qualifies the in-flight cycle still asserted
  always_comb begin
    strobe_on = 1'b0;
    case (cyc_q)
      CYC_MRD, CYC_IORD: strobe_on = !nRD;
      CYC_MWR, CYC_IOWR: strobe_on = !nWR;
      CYC_INTA:          strobe_on = !nIORQ;
      default:           strobe_on = 1'b0;
    endcase
  end

  // Next-state, datapath capture and one-cycle strobe generation
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    io_addr_d    = io_addr_q;
    io_wdata_d   = io_wdata_q;
    d_out_d      = d_out_q;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;
    io_wr_d      = 1'b0;
    io_rd_d      = 1'b0;
    intack_d     = 1'b0;
    rom_wr_err_d = 1'b0;
    do_act       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cyc_dec != CYC_NONE) begin
          cyc_d = cyc_dec;
          if (is_mem(cyc_dec)) begin
            mem_addr_d = A;
          end else if (cyc_dec != CYC_INTA) begin
            io_addr_d = A[7:0];
          end
          cnt_d = wait_ld;
          if (wait_ld != '0) begin
            state_d = ST_WAITCNT;
          end else begin
            do_act = 1'b1;
          end
        end
      end
      ST_WAITCNT: begin
        if (!strobe_on) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - WAITW'(1);
          if (cnt_q == WAITW'(1)) begin
            do_act = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (!strobe_on) begin
          state_d = ST_IDLE;
        end else begin
          case (cyc_q)
            CYC_MRD: begin
              // RAM answers the cycle after mem_re, so skip the strobe cycle
              if (!mem_re_q) begin
                d_out_d = mem_rdata;
                state_d = ST_DRIVE;
              end
            end
            CYC_IORD: begin
              d_out_d = io_rdata;
              state_d = ST_DRIVE;
            end
            default: begin
              d_out_d = int_vector;
              state_d = ST_DRIVE;
            end
          endcase
        end
      end
      ST_DRIVE: begin
        if (!strobe_on) begin
          state_d = ST_IDLE;
        end
      end
      ST_WRDONE: begin
        if (nWR) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_act) begin
      case (act_cyc)
        CYC_MRD: begin
          mem_re_d = 1'b1;
          state_d  = ST_FETCH;
        end
        CYC_IORD: begin
          io_rd_d = 1'b1;
          state_d = ST_FETCH;
        end
        CYC_INTA: begin
          intack_d = 1'b1;
          state_d  = ST_FETCH;
        end
        CYC_MWR: begin
          mem_wdata_d = D_in;
          if (rom_hit) begin
            rom_wr_err_d = 1'b1;
          end else begin
            mem_we_d = 1'b1;
          end
          state_d = ST_WRDONE;
        end
        CYC_IOWR: begin
          io_wdata_d = D_in;
          io_wr_d    = 1'b1;
          state_d    = ST_WRDONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers; reset abandons any cycle in flight
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q      <= ST_IDLE;
      cyc_q        <= CYC_NONE;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      io_addr_q    <= '0;
      io_wdata_q   <= '0;
      d_out_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      io_wr_q      <= 1'b0;
      io_rd_q      <= 1'b0;
      intack_q     <= 1'b0;
      rom_wr_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      io_addr_q    <= io_addr_d;
      io_wdata_q   <= io_wdata_d;
      d_out_q      <= d_out_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      io_wr_q      <= io_wr_d;
      io_rd_q      <= io_rd_d;
      intack_q     <= intack_d;
      rom_wr_err_q <= rom_wr_err_d;
    end
  end

  // D_oe is combinational so D is released in the same cycle the strobe rises
  assign D_oe       = (state_q == ST_DRIVE) && ((cyc_q == CYC_INTA) ? !nIORQ : !nRD);
  assign nWAIT      = (state_q != ST_WAITCNT);
  assign D_out      = d_out_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
  assign io_addr    = io_addr_q;
  assign io_wdata   = io_wdata_q;
  assign io_wr      = io_wr_q;
  assign io_rd      = io_rd_q;
  assign intack     = intack_q;
  assign rom_wr_err = rom_wr_err_q;

endmodule
